// File: rtl/c3lib_strap_capture.sv
// ----------------------------------------------------------------------------
// c3lib_strap_capture
//
// Sampling and lock stage for static configuration straps (tie cells / strap
// pads). The raw strap vector is synchronized, must then hold the same value
// for STABLE_CNT consecutive samples, and is then latched into strap_out with
// strap_valid. Once locked, the synchronized straps keep being compared with
// the latched word, and any difference sets the sticky strap_changed flag.
// The latched word itself never follows the pins after lock. Only a
// capture_req taken in LOCKED starts a new filter pass.
//
// Parameters
//   WIDTH        strap vector width (1..64)
//   SYNC_STAGES  synchronizer depth on strap_in (0..3, 0 = no synchronizer)
//   STABLE_CNT   identical consecutive samples needed to lock (1..65535)
//   RESET_VAL    strap_out value from reset until the first lock
//
// Ports
//   clk            block clock
//   rst            synchronous active-high reset
//   strap_in       raw strap values, asynchronous to clk
//   capture_req    re-capture request, only acted on while locked
//   clr_changed    clears strap_changed (a same-cycle set wins)
//   strap_out      latched configuration word
//   strap_valid    strap_out holds a locked value
//   strap_changed  sticky: synchronized straps differed from strap_out in LOCKED
//   busy           high while synchronizing / filtering
//
// Every output is a flop. There is no combinational path from any input.
// ----------------------------------------------------------------------------
module c3lib_strap_capture #(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      STABLE_CNT  = 16,
   parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] strap_in,
   input  logic             capture_req,
   input  logic             clr_changed,
   output logic [WIDTH-1:0] strap_out,
   output logic             strap_valid,
   output logic             strap_changed,
   output logic             busy
);

   // The counter is wide enough to hold STABLE_CNT itself, and it saturates
   // there, so it can never wrap.
   localparam int unsigned     CW       = $clog2(STABLE_CNT + 1);
   localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CNT);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   // SYNC always spends at least one cycle, even when the synchronizer is
   // bypassed, so the first filter sample comes from a clean post-reset edge.
   localparam int unsigned     SYNC_LEN  = (SYNC_STAGES == 0) ? 1 : SYNC_STAGES;
   localparam logic [1:0]      SYNC_LAST = 2'(SYNC_LEN - 1);

   typedef enum logic [1:0] {
      ST_SYNC   = 2'd0,
      ST_FILTER = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       sync_cnt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] s_prev;
   logic             changed_set;

   // ------------------------------------------------------------------------
   // Input synchronizer. s is the synchronized strap vector that every
   // decision below looks at.
   // ------------------------------------------------------------------------
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = strap_in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= strap_in;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Stability counter next value. A change reloads to 1, meaning this sample
   // is the first of a new run. Otherwise the counter counts up and sticks at
   // STABLE_CNT. The counter enters FILTER at 0, so the first filter sample
   // always gives 1, whatever s_prev holds.
   // ------------------------------------------------------------------------
   always_comb begin
      cnt_nxt = cnt;
      if (s != s_prev) begin
         cnt_nxt = CNT_ONE;
      end else if (cnt != CNT_MAX) begin
         cnt_nxt = cnt + CNT_ONE;
      end
   end

   // Mismatch against the held word only counts while locked. This includes
   // the cycle in which a capture_req is taken.
   assign changed_set = (state == ST_LOCKED) && (s != strap_out);

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_SYNC;
         sync_cnt      <= 2'd0;
         cnt           <= '0;
         s_prev        <= '0;
         strap_out     <= RESET_VAL;
         strap_valid   <= 1'b0;
         strap_changed <= 1'b0;
         busy          <= 1'b1;
      end else begin
         s_prev        <= s;
         // Set has priority over clear, so a persisting mismatch keeps the
         // flag up through a clr_changed pulse.
         strap_changed <= changed_set | (strap_changed & ~clr_changed);

         case (state)
            ST_SYNC: begin
               // Flush the synchronizer before trusting any sample.
               if (sync_cnt == SYNC_LAST) begin
                  state <= ST_FILTER;
               end else begin
                  sync_cnt <= sync_cnt + 2'd1;
               end
            end

            ST_FILTER: begin
               cnt <= cnt_nxt;
               // Lock on the same edge the run length reaches STABLE_CNT.
               // With STABLE_CNT=1 this is the very first filter sample.
               if (cnt_nxt == CNT_MAX) begin
                  strap_out   <= s;
                  strap_valid <= 1'b1;
                  busy        <= 1'b0;
                  state       <= ST_LOCKED;
               end
            end

            ST_LOCKED: begin
               // strap_out keeps its old value through the new filter pass.
               // Only strap_valid tells consumers that it is stale.
               if (capture_req) begin
                  strap_valid <= 1'b0;
                  busy        <= 1'b1;
                  cnt         <= '0;
                  state       <= ST_FILTER;
               end
            end

            default: begin
               state <= ST_SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_c3lib_strap_capture.sv
// ----------------------------------------------------------------------------
// tb_c3lib_strap_capture
//
// Two instances share the same stimulus: one with the default parameters and
// one with the minimum parameters (SYNC_STAGES=0, STABLE_CNT=1). A reference
// model checks both instances on every edge. The model treats the strap
// history as a sample window: lock happens once the last STABLE_CNT
// synchronized samples of the current filter pass are all equal. Directed
// checks against fixed constants cover the documented scenarios. A random
// phase follows them.
// ----------------------------------------------------------------------------
module tb_c3lib_strap_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] strap_in;
   logic       capture_req;
   logic       clr_changed;

   logic [7:0] out0, out1;
   logic       vld0, vld1, chg0, chg1, busy0, busy1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   c3lib_strap_capture #(
      .WIDTH(8), .SYNC_STAGES(2), .STABLE_CNT(16), .RESET_VAL(8'h00)
   ) dut0 (
      .clk(clk), .rst(rst), .strap_in(strap_in), .capture_req(capture_req),
      .clr_changed(clr_changed), .strap_out(out0), .strap_valid(vld0),
      .strap_changed(chg0), .busy(busy0)
   );

   c3lib_strap_capture #(
      .WIDTH(8), .SYNC_STAGES(0), .STABLE_CNT(1), .RESET_VAL(8'h00)
   ) dut1 (
      .clk(clk), .rst(rst), .strap_in(strap_in), .capture_req(capture_req),
      .clr_changed(clr_changed), .strap_out(out1), .strap_valid(vld1),
      .strap_changed(chg1), .busy(busy1)
   );

   // ------------------------------------------------------------------------
   // Reference model (index 0 = dut0, 1 = dut1)
   // ------------------------------------------------------------------------
   int         ss_p [2] = '{2, 0};
   int         sc_p [2] = '{16, 1};

   logic [7:0] m_out  [2];
   bit         m_vld  [2];
   bit         m_chg  [2];
   bit         m_busy [2];
   int         m_ph   [2];      // 0 = settling after reset, 1 = filtering, 2 = locked
   int         m_wait [2];      // settling edges still to go
   logic [7:0] dl     [2][4];   // strap_in as seen at past edges, [0] newest
   logic [7:0] win    [2][64];  // filter samples of this pass, [0] newest
   int         nwin   [2];

   task automatic model_reset(input int i);
      m_out[i]  = 8'h00;
      m_vld[i]  = 1'b0;
      m_chg[i]  = 1'b0;
      m_busy[i] = 1'b1;
      m_ph[i]   = 0;
      m_wait[i] = (ss_p[i] == 0) ? 1 : ss_p[i];
      nwin[i]   = 0;
      for (int j = 0; j < 4; j++) dl[i][j] = 8'h00;
   endtask

   task automatic model_edge(input int i);
      logic [7:0] s;
      bit         all_eq;
      // The value the block decides on at this edge: strap_in from
      // SYNC_STAGES edges ago, or the live pins when there is no synchronizer.
      s = (ss_p[i] == 0) ? strap_in : dl[i][ss_p[i]-1];
      if (rst) begin
         model_reset(i);
         return;
      end
      if (m_ph[i] == 2) m_chg[i] = (s != m_out[i]) || (m_chg[i] && !clr_changed);
      else              m_chg[i] = m_chg[i] && !clr_changed;
      case (m_ph[i])
         0: begin
            m_wait[i]--;
            if (m_wait[i] == 0) begin m_ph[i] = 1; nwin[i] = 0; end
         end
         1: begin
            for (int j = 63; j > 0; j--) win[i][j] = win[i][j-1];
            win[i][0] = s;
            nwin[i]++;
            all_eq = (nwin[i] >= sc_p[i]);
            for (int j = 0; j < sc_p[i]; j++)
               if (all_eq && win[i][j] != s) all_eq = 1'b0;
            if (all_eq) begin
               m_out[i] = s; m_vld[i] = 1'b1; m_busy[i] = 1'b0; m_ph[i] = 2;
            end
         end
         default: begin
            if (capture_req) begin
               m_vld[i] = 1'b0; m_busy[i] = 1'b1; m_ph[i] = 1; nwin[i] = 0;
            end
         end
      endcase
      for (int j = 3; j > 0; j--) dl[i][j] = dl[i][j-1];
      dl[i][0] = strap_in;
   endtask

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      chk("dut0.strap_out",     {56'd0, out0},  {56'd0, m_out[0]});
      chk("dut0.strap_valid",   {63'd0, vld0},  {63'd0, m_vld[0]});
      chk("dut0.strap_changed", {63'd0, chg0},  {63'd0, m_chg[0]});
      chk("dut0.busy",          {63'd0, busy0}, {63'd0, m_busy[0]});
      chk("dut1.strap_out",     {56'd0, out1},  {56'd0, m_out[1]});
      chk("dut1.strap_valid",   {63'd0, vld1},  {63'd0, m_vld[1]});
      chk("dut1.strap_changed", {63'd0, chg1},  {63'd0, m_chg[1]});
      chk("dut1.busy",          {63'd0, busy1}, {63'd0, m_busy[1]});
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int         hold;
      logic [7:0] pick [4];
      pick = '{8'hA5, 8'h5A, 8'h3C, 8'h00};
      hold = 0;
      model_reset(0);
      model_reset(1);

      rst = 1'b1; strap_in = 8'hA5; capture_req = 1'b0; clr_changed = 1'b0;
      repeat (3) tick();
      chk("reset_out",   {56'd0, out0},  64'h00);
      chk("reset_valid", {63'd0, vld0},  64'h0);
      chk("reset_busy",  {63'd0, busy0}, 64'h1);
      chk("reset_chg",   {63'd0, chg0},  64'h0);

      // Basic lock; the minimum-parameter instance locks after edge 2.
      rst = 1'b0;
      tick();
      chk("min_valid_e1", {63'd0, vld1}, 64'h0);
      tick();
      chk("min_valid_e2", {63'd0, vld1}, 64'h1);
      chk("min_out_e2",   {56'd0, out1}, 64'hA5);
      repeat (15) tick();
      chk("lock_valid_e17", {63'd0, vld0}, 64'h0);
      chk("lock_out_e17",   {56'd0, out0}, 64'h00);
      tick();
      chk("lock_valid_e18", {63'd0, vld0},  64'h1);
      chk("lock_out_e18",   {56'd0, out0},  64'hA5);
      chk("lock_busy_e18",  {63'd0, busy0}, 64'h0);

      // Post-lock change: the flag rises on the third edge.
      strap_in = 8'h00;
      repeat (2) tick();
      chk("chg_edge2", {63'd0, chg0}, 64'h0);
      tick();
      chk("chg_edge3", {63'd0, chg0}, 64'h1);
      chk("chg_out",   {56'd0, out0}, 64'hA5);
      clr_changed = 1'b1; tick(); clr_changed = 1'b0;
      chk("chg_clr_persist", {63'd0, chg0}, 64'h1);
      strap_in = 8'hA5;
      repeat (3) tick();
      clr_changed = 1'b1; tick(); clr_changed = 1'b0;
      chk("chg_cleared", {63'd0, chg0}, 64'h0);

      // Re-capture; a second request during FILTER is ignored.
      strap_in = 8'h3C;
      repeat (3) tick();
      capture_req = 1'b1; tick(); capture_req = 1'b0;
      chk("recap_valid_drop", {63'd0, vld0},  64'h0);
      chk("recap_out_hold",   {56'd0, out0},  64'hA5);
      chk("recap_busy",       {63'd0, busy0}, 64'h1);
      repeat (5) tick();
      capture_req = 1'b1; tick(); capture_req = 1'b0;
      repeat (9) tick();
      chk("recap_valid_n15", {63'd0, vld0}, 64'h0);
      tick();
      chk("recap_valid_n16", {63'd0, vld0}, 64'h1);
      chk("recap_out_n16",   {56'd0, out0}, 64'h3C);

      // Glitch filter: the last synchronized change is at edge 13, so the
      // lock comes at edge 28.
      strap_in = 8'hA5;
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (5) tick();
      strap_in = 8'h5A;
      repeat (5) tick();
      strap_in = 8'hA5;
      for (int e = 11; e <= 27; e++) begin
         tick();
         chk("glitch_out_pre",   {56'd0, out0}, 64'h00);
         chk("glitch_valid_pre", {63'd0, vld0}, 64'h0);
      end
      tick();
      chk("glitch_valid_lock", {63'd0, vld0}, 64'h1);
      chk("glitch_out_lock",   {56'd0, out0}, 64'hA5);

      // Reset at filter count 10, then a full 18-edge lock again.
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (12) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_out",   {56'd0, out0},  64'h00);
      chk("midrst_valid", {63'd0, vld0},  64'h0);
      chk("midrst_busy",  {63'd0, busy0}, 64'h1);
      repeat (17) tick();
      chk("midrst_valid_e17", {63'd0, vld0}, 64'h0);
      tick();
      chk("midrst_valid_e18", {63'd0, vld0}, 64'h1);
      chk("midrst_out_e18",   {56'd0, out0}, 64'hA5);

      // Random phase: bursty strap values plus sparse requests and resets.
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 4) == 0) strap_in = 8'($urandom);
            else                           strap_in = pick[$urandom_range(0, 3)];
            hold = $urandom_range(1, 40);
         end
         hold--;
         capture_req = ($urandom_range(0, 29) == 0);
         clr_changed = ($urandom_range(0, 9) == 0);
         rst         = ($urandom_range(0, 399) == 0);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
